// File: rtl/mat_mul_seq.sv
// mat_mul_seq: issue/track sequencer for an N x N matrix-multiply datapath.
// Ports: clk/rst, start/hold in; busy/done, rd_* issue, pipe_en, wr_* out.
module mat_mul_seq #(
  parameter int N        = 4,
  parameter int PIPE_LAT = 4,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_row,
  output logic [IDX_W-1:0]   rd_col,
  output logic               pipe_en,
  output logic               wr_en,
  output logic [2*IDX_W-1:0] wr_addr
);

  localparam int AW = 2 * IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [AW-1:0] NW = AW'(N);
  localparam logic [PIPE_LAT-1:0] TAIL_M =
    PIPE_LAT'(1) << (PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] row, col;
  logic [IDX_W-1:0] row_nx, col_nx;

  logic [PIPE_LAT-1:0] vld;
  logic [IDX_W-1:0]    trow [PIPE_LAT];
  logic [IDX_W-1:0]    tcol [PIPE_LAT];

  logic frz;
  logic last_iss;
  logic drain_ok;

  // hold only freezes an active job
  assign frz = hold &
    ((state == ISSUE) | (state == DRAIN));

  assign last_iss = (row == LAST) & (col == LAST);

  // everything ahead of the tail is empty, so the
  // tail (if valid) is the final write
  assign drain_ok = (vld & ~TAIL_M) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          row_nx   = '0;
          col_nx   = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          if (col == LAST) begin
            col_nx = '0;
            row_nx = (row == LAST) ? '0 : row + 1'b1;
          end else begin
            col_nx = col + 1'b1;
          end
          if (last_iss) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!hold && drain_ok) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        trow[i] <= '0;
        tcol[i] <= '0;
      end
    end else if (pipe_en) begin
      vld[0]  <= rd_en;
      trow[0] <= row;
      tcol[0] <= col;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld[i]  <= vld[i-1];
        trow[i] <= trow[i-1];
        tcol[i] <= tcol[i-1];
      end
    end
  end

  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign pipe_en = ~frz;
  assign rd_en   = (state == ISSUE) & ~hold;
  assign rd_row  = row;
  assign rd_col  = col;
  assign wr_en   = vld[PIPE_LAT-1] & ~frz;
  assign wr_addr = AW'(trow[PIPE_LAT-1]) * NW +
                   AW'(tcol[PIPE_LAT-1]);

endmodule

// File: tb/tb_mat_mul_seq.sv
// tb_mat_mul_seq: directed + random checks of mat_mul_seq against
// an event-count model and a behavioural fixed-point datapath.
module tb_mat_mul_seq;

  localparam int FR = 8;

  logic clk = 1'b0;
  logic rst;
  logic start0, hold0, start1, hold1;

  logic       busy0, done0, rd_en0, pipe_en0, wr_en0;
  logic [1:0] rd_row0, rd_col0;
  logic [3:0] wr_addr0;

  logic       busy1, done1, rd_en1, pipe_en1, wr_en1;
  logic [0:0] rd_row1, rd_col1;
  logic [1:0] wr_addr1;

  int checks = 0;
  int errors = 0;

  int A [4][4];
  int B [4][4];
  int C [16];
  int dp [4];

  always #5 clk = ~clk;

  mat_mul_seq #(.N(4), .PIPE_LAT(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .hold(hold0),
    .busy(busy0), .done(done0), .rd_en(rd_en0),
    .rd_row(rd_row0), .rd_col(rd_col0), .pipe_en(pipe_en0),
    .wr_en(wr_en0), .wr_addr(wr_addr0)
  );

  mat_mul_seq #(.N(2), .PIPE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .busy(busy1), .done(done1), .rd_en(rd_en1),
    .rd_row(rd_row1), .rd_col(rd_col1), .pipe_en(pipe_en1),
    .wr_en(wr_en1), .wr_addr(wr_addr1)
  );

  function automatic int dot(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 4; k++) s += A[r][k] * B[k][c];
    return s >>> FR;
  endfunction

  // stand-in datapath: PIPE_LAT stages, frozen by pipe_en
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dp[i] <= 0;
    end else begin
      if (wr_en0) C[wr_addr0] <= dp[3];
      if (pipe_en0) begin
        dp[0] <= rd_en0 ? dot(int'(rd_row0), int'(rd_col0)) : 0;
        for (int i = 1; i < 4; i++) dp[i] <= dp[i-1];
      end
    end
  end

  typedef struct {
    logic [31:0] busy, done, rd_en, row, col;
    logic [31:0] pen, wr_en, addr;
  } obs_t;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = 32'(busy0); o.done = 32'(done0);
      o.rd_en = 32'(rd_en0); o.row = 32'(rd_row0);
      o.col = 32'(rd_col0); o.pen = 32'(pipe_en0);
      o.wr_en = 32'(wr_en0); o.addr = 32'(wr_addr0);
    end else begin
      o.busy = 32'(busy1); o.done = 32'(done1);
      o.rd_en = 32'(rd_en1); o.row = 32'(rd_row1);
      o.col = 32'(rd_col1); o.pen = 32'(pipe_en1);
      o.wr_en = 32'(wr_en1); o.addr = 32'(wr_addr1);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] ob,
                     input logic [31:0] ex);
    checks++;
    assert (ob === ex) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, ob, ex);
    end
  endtask

  task automatic drive(input int d, input bit s, input bit h);
    if (d == 0) begin start0 = s; hold0 = h; end
    else begin start1 = s; hold1 = h; end
  endtask

  // Model: the job advances only on non-hold cycles. Issue k falls on
  // active cycle k+1, its write on active cycle k+1+pl; done follows
  // the (n*n+pl)-th active cycle, then one idle cycle.
  task automatic run_job(input int d, input int n, input int pl,
                         input bit hq[$], input bit sq[$],
                         input bit chained);
    obs_t o;
    int act = 0;
    bit dn = 0;
    bit fin = 0;
    bit s, h;
    if (!chained) begin
      @(negedge clk);
      drive(d, 1'b1, 1'b0);
      #2;
      o = get_obs(d);
      chk("idle_busy", o.busy, 0);
      chk("idle_pipe_en", o.pen, 1);
    end
    for (int rel = 1; rel < 400 && !fin; rel++) begin
      @(negedge clk);
      s = (rel - 1 < sq.size()) ? sq[rel-1] : 1'b0;
      h = (rel - 1 < hq.size()) ? hq[rel-1] : 1'b0;
      drive(d, s, h);
      #2;
      o = get_obs(d);
      if (dn) begin
        chk("done_pulse", o.done, 1);
        chk("done_busy", o.busy, 1);
        chk("done_rd_en", o.rd_en, 0);
        chk("done_wr_en", o.wr_en, 0);
        @(negedge clk);
        s = (rel < sq.size()) ? sq[rel] : 1'b0;
        h = (rel < hq.size()) ? hq[rel] : 1'b0;
        drive(d, s, h);
        #2;
        o = get_obs(d);
        chk("end_busy", o.busy, 0);
        chk("end_done", o.done, 0);
        chk("end_rd_en", o.rd_en, 0);
        chk("end_wr_en", o.wr_en, 0);
        chk("end_pipe_en", o.pen, 1);
        fin = 1;
      end else begin
        chk("run_busy", o.busy, 1);
        chk("run_done", o.done, 0);
        if (h) begin
          chk("hold_rd_en", o.rd_en, 0);
          chk("hold_wr_en", o.wr_en, 0);
          chk("hold_pipe_en", o.pen, 0);
        end else begin
          act++;
          chk("run_pipe_en", o.pen, 1);
          chk("rd_en", o.rd_en, 32'(act <= n * n));
          if (act <= n * n) begin
            chk("rd_row", o.row, (act - 1) / n);
            chk("rd_col", o.col, (act - 1) % n);
          end
          chk("wr_en", o.wr_en,
              32'(act > pl && act <= n * n + pl));
          if (act > pl && act <= n * n + pl)
            chk("wr_addr", o.addr, act - pl - 1);
          if (act == n * n + pl) dn = 1;
        end
      end
    end
    chk("job_finished", 32'(fin), 1);
  endtask

  task automatic clear_c();
    for (int i = 0; i < 16; i++) C[i] = -1;
  endtask

  task automatic check_product(input string tag);
    int e;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        e = 0;
        for (int k = 0; k < 4; k++) e += A[i][k] * B[k][j];
        chk(tag, C[i*4+j], e >>> FR);
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = int'($urandom_range(0, 1023));
        B[i][j] = int'($urandom_range(0, 1023));
      end
  endtask

  initial begin
    bit hq[$];
    bit sq[$];
    obs_t o;
    rst = 1'b1;
    drive(0, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = (i == j) ? (1 << FR) : 0;
        B[i][j] = (i * 4 + j + 1) << FR;
      end
    clear_c();
    repeat (2) @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      chk("rst_busy", o.busy, 0);
      chk("rst_done", o.done, 0);
      chk("rst_rd_en", o.rd_en, 0);
      chk("rst_wr_en", o.wr_en, 0);
      chk("rst_rd_row", o.row, 0);
      chk("rst_rd_col", o.col, 0);
      chk("rst_wr_addr", o.addr, 0);
      chk("rst_pipe_en", o.pen, 1);
    end
    rst = 1'b0;

    // plain job; identity x ramp must reproduce B
    hq = {};
    sq = {};
    run_job(0, 4, 4, hq, sq, 1'b0);
    for (int i = 0; i < 16; i++)
      chk("ident_val", C[i], (i + 1) << FR);

    // directed holds at cycles 3-5 and 18, random operands
    rand_mats();
    clear_c();
    hq = {};
    for (int i = 0; i < 20; i++)
      hq.push_back(i >= 2 && i <= 4 || i == 17);
    run_job(0, 4, 4, hq, sq, 1'b0);
    check_product("hold_prod");

    // random holds, including in the done and idle cycles
    rand_mats();
    clear_c();
    hq = {};
    for (int i = 0; i < 60; i++)
      hq.push_back($urandom_range(0, 3) == 0);
    run_job(0, 4, 4, hq, sq, 1'b0);
    check_product("rhold_prod");

    // second pulse at 7 ignored; start high through done chains a job
    hq = {};
    sq = {};
    for (int i = 0; i < 22; i++)
      sq.push_back(i == 6 || i >= 14);
    run_job(0, 4, 4, hq, sq, 1'b0);
    clear_c();
    sq = {};
    run_job(0, 4, 4, hq, sq, 1'b1);
    check_product("chain_prod");

    // reset at cycle 10 mid-issue, with start in the same cycle
    rand_mats();
    @(negedge clk);
    drive(0, 1, 0);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      drive(0, 0, 0);
    end
    @(negedge clk);
    drive(0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    #2;
    o = get_obs(0);
    chk("mid_rst_busy", o.busy, 0);
    chk("mid_rst_done", o.done, 0);
    chk("mid_rst_wr_en", o.wr_en, 0);
    chk("mid_rst_rd_en", o.rd_en, 0);
    clear_c();
    run_job(0, 4, 4, hq, sq, 1'b0);
    check_product("rst_prod");

    // N=2, PIPE_LAT=1: plain, then with random holds
    hq = {};
    run_job(1, 2, 1, hq, sq, 1'b0);
    for (int i = 0; i < 16; i++)
      hq.push_back($urandom_range(0, 2) == 0);
    run_job(1, 2, 1, hq, sq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
